hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Sequences multiply/divide and owns the HI/LO registers for the MIPS pipeline EX stage. It is driven by the decoder's MULT, DIV, MFHL and MTHL signals together with the rs/rt operand values. It holds EX stalled while a multiply or iterative divide is in flight, writes HI/LO on completion, and serves MFHI/MFLO reads and MTHI/MTLO writes. A restoring radix-2 divider core is instantiated inside.

Parameters:
DATA_W, 32, operand/HI/LO width
MUL_LAT, 2, cycles spent in MUL state before HI/LO write (>=1)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction
ex_cancel  in  1  EX instruction cancelled; aborts any op in flight
mult_op  in  2  [1]=multu, [0]=mult (decoder MULT)
div_op  in  2  [1]=divu, [0]=div (decoder DIV)
mfhl_op  in  2  [1]=mfhi, [0]=mflo
mthl_op  in  2  [1]=mthi, [0]=mtlo
rs_value  in  DATA_W  operand A / MT source
rt_value  in  DATA_W  operand B
md_stall  out  1  hold EX (and upstream) this cycle
mfhl_value  out  DATA_W  HI if mfhl_op[1], else LO if mfhl_op[0], else 0
hi_q  out  DATA_W  current HI
lo_q  out  DATA_W  current LO

Behaviour:
- Interface: one clock clk; reset resetn is synchronous, active-low. On resetn=0 at a clock edge: state=IDLE, HI=LO=0, counter=0, divider core cleared. md_stall=0 during reset.
- start = ex_valid & ~ex_cancel & (|div_op | |mult_op), evaluated in IDLE only. div_op has priority over mult_op. Encodings 2'b11 on any op bus are illegal; they are treated as their bit[1] (unsigned) form.
- IDLE: on start, latch rs/rt and signedness, assert md_stall combinationally in the same cycle. Go to MUL with cnt=MUL_LAT-1, or go to DIV and pulse the core start.
- MUL: md_stall=1. Product is a registered 33x33 signed multiply of sign/zero-extended operands. When cnt==0: HI=prod[63:32], LO=prod[31:0], go to DONE. Otherwise cnt--.
- DIV: md_stall=1. Core runs on magnitudes for exactly DATA_W cycles, then goes to FIX.
- FIX: md_stall=1. Sign fixup: quotient negated if sign(a)^sign(b); remainder takes sign(a). Write LO=quotient, HI=remainder. Go to DONE.
- DONE: md_stall=0 for exactly one cycle so the instruction leaves EX. start is ignored in this state. Next state is IDLE.
- Latency: the mul/div instruction sees md_stall high for 1+MUL_LAT cycles (mult) or 1+DATA_W+1 cycles (div), then one low cycle in DONE.
- Divide by zero: HI=dividend (rs_value as latched), LO=all-ones. Duration is unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI/MTLO: in IDLE with ex_valid & ~ex_cancel, write HI or LO from rs_value at the clock edge. No stall. An instruction in the next cycle reads the new value.
- mfhl_value is combinational from the HI/LO registers. No read happens while busy, because the pipeline is stalled.
- ex_cancel in MUL/DIV/FIX: return to IDLE next edge, HI/LO unchanged, md_stall=0 that cycle.
- resetn low mid-operation: immediate return to IDLE; the result is discarded.

Decomposition:
- Shared package: state encoding (IDLE, MUL, DIV, FIX, DONE), op-bit index constants for MULT/DIV/MFHL/MTHL, DATA_W default.
- Sub-module: div_restoring_core (inputs start/dividend/divisor magnitudes; outputs done, quotient, remainder; DATA_W iterations).

Test Plan:
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> md_stall high 3 cycles, then low 1 cycle; HI=0xFFFFFFFE, LO=0x00000001.
- mult rs=0xFFFFFFFD(-3) rt=0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div rs=0xFFFFFFF9(-7) rt=2 -> stall 34 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 -> LO=14, HI=2.
- divu rs=0x12345678 rt=0 -> HI=0x12345678, LO=0xFFFFFFFF. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- mthi rs=0xAAAA5555 then mfhi next cycle -> mfhl_value=0xAAAA5555, md_stall never asserted. mtlo leaves HI unchanged.
- div started, ex_cancel at iteration 10 -> state IDLE next cycle, HI/LO keep prior values. Repeat the same scenario with resetn=0 at iteration 20 -> HI=LO=0, md_stall=0.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide controller: FSM state
// encoding, decoder op-bus bit positions and default widths.
package hilo_muldiv_ctrl_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int MUL_LAT_DEF = 2;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

    // MULT / DIV op buses: [1] = unsigned form, [0] = signed form
    localparam int OP_UNSIGNED_BIT = 1;
    localparam int OP_SIGNED_BIT   = 0;

    // MFHL / MTHL op buses: [1] = HI, [0] = LO
    localparam int HL_HI_BIT = 1;
    localparam int HL_LO_BIT = 0;

    // An op is signed only for the pure signed encoding; the illegal 2'b11
    // collapses onto the unsigned form.
    function automatic logic op_is_signed(input logic [1:0] op);
        return op[OP_SIGNED_BIT] & ~op[OP_UNSIGNED_BIT];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Decoder/operand bundle between the EX stage and the HI/LO controller.
interface hilo_muldiv_ctrl_if
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              ex_valid;
    logic              ex_cancel;
    logic [1:0]        mult_op;
    logic [1:0]        div_op;
    logic [1:0]        mfhl_op;
    logic [1:0]        mthl_op;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] rt_value;
    logic              md_stall;
    logic [DATA_W-1:0] mfhl_value;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    // EX stage side
    modport master (
        output ex_valid, ex_cancel, mult_op, div_op, mfhl_op, mthl_op,
               rs_value, rt_value,
        input  md_stall, mfhl_value, hi_q, lo_q
    );

    // Controller side
    modport slave (
        input  ex_valid, ex_cancel, mult_op, div_op, mfhl_op, mthl_op,
               rs_value, rt_value,
        output md_stall, mfhl_value, hi_q, lo_q
    );

endinterface

// File: rtl/hilo_muldiv_ctrl_div_restoring_core.sv
// Unsigned restoring radix-2 divider: one quotient bit per cycle, DATA_W
// iterations after start. done pulses for one cycle once results are final.
module div_restoring_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] dsr_r;
    logic [ITER_W-1:0] iter_r;
    logic              busy_r;
    logic              done_r;

    logic [DATA_W:0]   shifted_s;
    logic [DATA_W:0]   trial_s;
    logic              fits_s;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        shifted_s = {rem_r, quo_r[DATA_W-1]};
        trial_s   = shifted_s - {1'b0, dsr_r};
        fits_s    = (shifted_s >= {1'b0, dsr_r});
    end

    // Iteration state: quotient bits shift in at the bottom as dividend bits leave the top
    always_ff @(posedge clk) begin
        if (!resetn || abort) begin
            quo_r  <= {DATA_W{1'b0}};
            rem_r  <= {DATA_W{1'b0}};
            dsr_r  <= {DATA_W{1'b0}};
            iter_r <= {ITER_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            quo_r  <= dividend;
            rem_r  <= {DATA_W{1'b0}};
            dsr_r  <= divisor;
            iter_r <= {ITER_W{1'b0}};
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            quo_r  <= {quo_r[DATA_W-2:0], fits_s};
            rem_r  <= fits_s ? trial_s[DATA_W-1:0] : shifted_s[DATA_W-1:0];
            if (iter_r == ITER_LAST) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                iter_r <= iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done      = done_r;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and owner of the HI/LO registers.
// Stalls EX while an op is in flight, writes HI/LO on completion and serves
// MFHI/MFLO reads and MTHI/MTLO writes while idle.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    hilo_muldiv_ctrl_if.slave md_bus
);
    localparam int CNT_MAX = (MUL_LAT > DATA_W) ? MUL_LAT : DATA_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic            is_signed);
        return (is_signed && v[DATA_W-1]) ? negate(v) : v;
    endfunction

    md_state_e           state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   op_a_r;
    logic [DATA_W-1:0]   op_b_r;
    logic                sign_r;
    logic [2*DATA_W-1:0] prod_r;

    logic                is_div_s;
    logic                issue_s;
    logic                start_s;
    logic                op_signed_s;
    logic                busy_s;
    logic                md_stall_s;
    logic [DATA_W-1:0]   mfhl_s;
    logic [DATA_W:0]     a_ext_s;
    logic [DATA_W:0]     b_ext_s;
    logic [2*DATA_W-1:0] a_wide_s;
    logic [2*DATA_W-1:0] b_wide_s;
    logic [2*DATA_W-1:0] prod_s;
    logic                div_start_s;
    logic                div_abort_s;
    logic                div_done_s;
    logic [DATA_W-1:0]   div_quo_s;
    logic [DATA_W-1:0]   div_rem_s;
    logic                neg_q_s;
    logic                neg_r_s;
    logic [DATA_W-1:0]   quo_fix_s;
    logic [DATA_W-1:0]   rem_fix_s;

    // Decode the launch request and the EX stall; stall is dropped on cancel and in reset
    always_comb begin
        is_div_s    = |md_bus.div_op;
        issue_s     = md_bus.ex_valid & ~md_bus.ex_cancel;
        start_s     = resetn & (state_r == ST_IDLE) & issue_s &
                      (is_div_s | (|md_bus.mult_op));
        if (is_div_s) begin
            op_signed_s = op_is_signed(md_bus.div_op);
        end else begin
            op_signed_s = op_is_signed(md_bus.mult_op);
        end
        busy_s      = (state_r == ST_MUL) | (state_r == ST_DIV) | (state_r == ST_FIX);
        md_stall_s  = resetn & (start_s | (busy_s & ~md_bus.ex_cancel));
        div_start_s = start_s & is_div_s;
        div_abort_s = (state_r == ST_DIV) & md_bus.ex_cancel;
        if (md_bus.mfhl_op[HL_HI_BIT]) begin
            mfhl_s = hi_r;
        end else if (md_bus.mfhl_op[HL_LO_BIT]) begin
            mfhl_s = lo_r;
        end else begin
            mfhl_s = {DATA_W{1'b0}};
        end
    end

    // 33x33 signed product of sign/zero-extended operands; only the low 2*DATA_W bits are kept
    always_comb begin
        a_ext_s  = {op_signed_s & md_bus.rs_value[DATA_W-1], md_bus.rs_value};
        b_ext_s  = {op_signed_s & md_bus.rt_value[DATA_W-1], md_bus.rt_value};
        a_wide_s = {{(DATA_W-1){a_ext_s[DATA_W]}}, a_ext_s};
        b_wide_s = {{(DATA_W-1){b_ext_s[DATA_W]}}, b_ext_s};
        prod_s   = a_wide_s * b_wide_s;
    end

    // Sign fixup of the magnitude result; divide-by-zero returns dividend / all-ones
    always_comb begin
        neg_q_s = sign_r & (op_a_r[DATA_W-1] ^ op_b_r[DATA_W-1]);
        neg_r_s = sign_r & op_a_r[DATA_W-1];
        if (op_b_r == {DATA_W{1'b0}}) begin
            quo_fix_s = {DATA_W{1'b1}};
            rem_fix_s = op_a_r;
        end else begin
            if (neg_q_s) begin
                quo_fix_s = negate(div_quo_s);
            end else begin
                quo_fix_s = div_quo_s;
            end
            if (neg_r_s) begin
                rem_fix_s = negate(div_rem_s);
            end else begin
                rem_fix_s = div_rem_s;
            end
        end
    end

    div_restoring_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .clk       (clk),
        .resetn    (resetn),
        .abort     (div_abort_s),
        .start     (div_start_s),
        .dividend  (magnitude(md_bus.rs_value, op_signed_s)),
        .divisor   (magnitude(md_bus.rt_value, op_signed_s)),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Sequencer FSM owning HI/LO, the latched operands and the latency counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {DATA_W{1'b0}};
            lo_r    <= {DATA_W{1'b0}};
            op_a_r  <= {DATA_W{1'b0}};
            op_b_r  <= {DATA_W{1'b0}};
            sign_r  <= 1'b0;
            prod_r  <= {(2*DATA_W){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        op_a_r <= md_bus.rs_value;
                        op_b_r <= md_bus.rt_value;
                        sign_r <= op_signed_s;
                        if (is_div_s) begin
                            cnt_r   <= DIV_CNT_INIT;
                            state_r <= ST_DIV;
                        end else begin
                            prod_r  <= prod_s;
                            cnt_r   <= MUL_CNT_INIT;
                            state_r <= ST_MUL;
                        end
                    end else if (issue_s) begin
                        // Illegal 2'b11 behaves as the HI form
                        if (md_bus.mthl_op[HL_HI_BIT]) begin
                            hi_r <= md_bus.rs_value;
                        end else if (md_bus.mthl_op[HL_LO_BIT]) begin
                            lo_r <= md_bus.rs_value;
                        end
                    end
                end
                ST_MUL: begin
                    if (md_bus.ex_cancel) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        hi_r    <= prod_r[2*DATA_W-1:DATA_W];
                        lo_r    <= prod_r[DATA_W-1:0];
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DIV: begin
                    if (md_bus.ex_cancel) begin
                        state_r <= ST_IDLE;
                    end else if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_FIX: begin
                    if (md_bus.ex_cancel) begin
                        state_r <= ST_IDLE;
                    end else begin
                        if (div_done_s) begin
                            lo_r <= quo_fix_s;
                            hi_r <= rem_fix_s;
                        end
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign md_bus.md_stall   = md_stall_s;
    assign md_bus.mfhl_value = mfhl_s;
    assign md_bus.hi_q       = hi_r;
    assign md_bus.lo_q       = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed and randomized
// multiply/divide/move ops checked against a plain-arithmetic reference.
module tb_hilo_muldiv_ctrl;

    localparam int DW        = 32;
    localparam int MUL_LAT   = 2;
    localparam int MUL_STALL = 1 + MUL_LAT;
    localparam int DIV_STALL = 1 + DW + 1;

    localparam int K_MULT  = 0;
    localparam int K_MULTU = 1;
    localparam int K_DIV   = 2;
    localparam int K_DIVU  = 3;

    logic        clk = 1'b0;
    logic        resetn;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    hilo_muldiv_ctrl_if #(.DATA_W(DW)) md_bus ();

    hilo_muldiv_ctrl #(
        .DATA_W  (DW),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .md_bus (md_bus)
    );

    always #5 clk = ~clk;

    // Reference: MIPS HI/LO results from plain 64-bit arithmetic
    function automatic void ref_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        case (kind)
            K_MULT: begin
                p  = sa * sb;
                hi = p[63:32];
                lo = p[31:0];
            end
            K_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            K_DIV: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    hi = r[31:0];
                    lo = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
            end
        endcase
    endfunction

    task automatic clear_inputs;
        md_bus.ex_valid  = 1'b0;
        md_bus.ex_cancel = 1'b0;
        md_bus.mult_op   = 2'b00;
        md_bus.div_op    = 2'b00;
        md_bus.mfhl_op   = 2'b00;
        md_bus.mthl_op   = 2'b00;
        md_bus.rs_value  = 32'd0;
        md_bus.rt_value  = 32'd0;
    endtask

    task automatic drive_op(input int kind, input logic [1:0] enc,
                            input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        md_bus.ex_valid = 1'b1;
        if (kind == K_MULT || kind == K_MULTU) md_bus.mult_op = enc;
        else md_bus.div_op = enc;
        md_bus.rs_value = a;
        md_bus.rt_value = b;
    endtask

    // Issue one mul/div and hold it in EX until md_stall drops; entry at posedge+1
    task automatic do_op(input string name, input int kind, input logic [1:0] enc,
                         input logic [31:0] a, input logic [31:0] b);
        int          stalls;
        int          exp_stalls;
        bit          seen_low;
        logic [31:0] eh, el;
        ref_op(kind, a, b, eh, el);
        exp_stalls = (kind == K_MULT || kind == K_MULTU) ? MUL_STALL : DIV_STALL;
        drive_op(kind, enc, a, b);
        stalls   = 0;
        seen_low = 1'b0;
        for (int c = 0; c < 100 && !seen_low; c++) begin
            @(negedge clk);
            if (md_bus.md_stall) begin
                stalls++;
            end else begin
                seen_low = 1'b1;
                n_checks++;
                if (stalls !== exp_stalls) begin
                    n_fail++;
                    $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_stalls);
                end
                n_checks++;
                if (md_bus.hi_q !== eh || md_bus.lo_q !== el) begin
                    n_fail++;
                    $display("FAIL %s hilo a=%h b=%h: got HI=%h LO=%h expected HI=%h LO=%h",
                             name, a, b, md_bus.hi_q, md_bus.lo_q, eh, el);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!seen_low) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: md_stall still high after 100 cycles, expected low after %0d",
                     name, exp_stalls);
        end
        clear_inputs();
        model_hi = eh;
        model_lo = el;
    endtask

    // MFHI then MFLO in consecutive cycles; neither may stall
    task automatic read_hilo(input string name);
        clear_inputs();
        md_bus.ex_valid = 1'b1;
        md_bus.mfhl_op  = 2'b10;
        @(negedge clk);
        n_checks++;
        if (md_bus.mfhl_value !== model_hi || md_bus.md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s mfhi: got %h stall=%b expected %h stall=0",
                     name, md_bus.mfhl_value, md_bus.md_stall, model_hi);
        end
        @(posedge clk);
        #1;
        md_bus.mfhl_op = 2'b01;
        @(negedge clk);
        n_checks++;
        if (md_bus.mfhl_value !== model_lo || md_bus.md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s mflo: got %h stall=%b expected %h stall=0",
                     name, md_bus.mfhl_value, md_bus.md_stall, model_lo);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        drive_op(K_MULT, 2'b01, 32'd5, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0 || md_bus.hi_q !== 32'd0 || md_bus.lo_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got stall=%b HI=%h LO=%h expected 0/0/0",
                     md_bus.md_stall, md_bus.hi_q, md_bus.lo_q);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        resetn   = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        read_hilo("post_reset");
    endtask

    task automatic test_plan_vectors;
        do_op("multu_ff",   K_MULTU, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_hilo("multu_ff_rd");
        do_op("mult_m3x5",  K_MULT,  2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        do_op("div_m7_2",   K_DIV,   2'b01, 32'hFFFF_FFF9, 32'h0000_0002);
        read_hilo("div_m7_2_rd");
        do_op("divu_100_7", K_DIVU,  2'b10, 32'd100,       32'd7);
        do_op("divu_by0",   K_DIVU,  2'b10, 32'h1234_5678, 32'd0);
        do_op("div_by0",    K_DIV,   2'b01, 32'h8765_4321, 32'd0);
        do_op("div_ovf",    K_DIV,   2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("multu_enc11", K_MULTU, 2'b11, 32'h8000_0001, 32'hFFFF_FFFF);
        do_op("divu_enc11",  K_DIVU,  2'b11, 32'hFFFF_FFF9, 32'd2);
        read_hilo("plan_rd");
    endtask

    task automatic test_mthl;
        // mthi: no stall in the write cycle
        clear_inputs();
        md_bus.ex_valid = 1'b1;
        md_bus.mthl_op  = 2'b10;
        md_bus.rs_value = 32'hAAAA_5555;
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_stall: got %b expected 0", md_bus.md_stall);
        end
        @(posedge clk);
        #1;
        model_hi = 32'hAAAA_5555;
        read_hilo("mthi_rd");
        // mtlo must leave HI alone
        md_bus.ex_valid = 1'b1;
        md_bus.mthl_op  = 2'b01;
        md_bus.rs_value = 32'h0F0F_1234;
        @(posedge clk);
        #1;
        model_lo = 32'h0F0F_1234;
        read_hilo("mtlo_rd");
        // illegal 2'b11 writes HI only
        md_bus.ex_valid = 1'b1;
        md_bus.mthl_op  = 2'b11;
        md_bus.rs_value = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        model_hi = 32'h1357_9BDF;
        read_hilo("mthl11_rd");
        // cancelled or invalid moves write nothing
        md_bus.ex_valid  = 1'b1;
        md_bus.ex_cancel = 1'b1;
        md_bus.mthl_op   = 2'b10;
        md_bus.rs_value  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        md_bus.ex_valid  = 1'b0;
        md_bus.ex_cancel = 1'b0;
        md_bus.mthl_op   = 2'b01;
        @(posedge clk);
        #1;
        read_hilo("mthl_blocked_rd");
        // mfhl_op 00 reads zero, 11 reads HI
        md_bus.mfhl_op = 2'b00;
        @(negedge clk);
        n_checks++;
        if (md_bus.mfhl_value !== 32'd0) begin
            n_fail++;
            $display("FAIL mfhl_none: got %h expected 00000000", md_bus.mfhl_value);
        end
        md_bus.mfhl_op = 2'b11;
        #1;
        n_checks++;
        if (md_bus.mfhl_value !== model_hi) begin
            n_fail++;
            $display("FAIL mfhl11: got %h expected %h", md_bus.mfhl_value, model_hi);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Cancel after a number of in-flight cycles: HI/LO untouched, stall drops at once
    task automatic cancel_after(input string name, input int kind, input logic [1:0] enc,
                                input int cycles);
        logic [31:0] prev_hi, prev_lo;
        prev_hi = model_hi;
        prev_lo = model_lo;
        drive_op(kind, enc, 32'hFFFF_0123, 32'h0000_0031);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        md_bus.ex_cancel = 1'b1;
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cancel_stall: got %b expected 0", name, md_bus.md_stall);
        end
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0 || md_bus.hi_q !== prev_hi || md_bus.lo_q !== prev_lo) begin
            n_fail++;
            $display("FAIL %s after_cancel: got stall=%b HI=%h LO=%h expected 0/%h/%h",
                     name, md_bus.md_stall, md_bus.hi_q, md_bus.lo_q, prev_hi, prev_lo);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cancel;
        do_op("pre_cancel", K_MULT, 2'b01, 32'h0001_2345, 32'hFFFF_FF00);
        cancel_after("div_cancel", K_DIV, 2'b01, 11);
        do_op("post_div_cancel", K_MULTU, 2'b10, 32'd123456, 32'd789);
        cancel_after("mul_cancel", K_MULT, 2'b01, 2);
        do_op("post_mul_cancel", K_DIVU, 2'b10, 32'd1000, 32'd33);
    endtask

    task automatic test_reset_mid;
        do_op("pre_reset", K_MULTU, 2'b10, 32'hCAFE_0001, 32'h0000_1111);
        drive_op(K_DIV, 2'b01, 32'h7654_3210, 32'hFFFF_FFF3);
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %b expected 0", md_bus.md_stall);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_inputs();
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        n_checks++;
        if (md_bus.md_stall !== 1'b0 || md_bus.hi_q !== 32'd0 || md_bus.lo_q !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_hilo: got stall=%b HI=%h LO=%h expected 0/0/0",
                     md_bus.md_stall, md_bus.hi_q, md_bus.lo_q);
        end
        @(posedge clk);
        #1;
        do_op("post_reset_div", K_DIV, 2'b01, 32'h7654_3210, 32'hFFFF_FFF3);
    endtask

    task automatic test_back_to_back;
        do_op("b2b_0", K_DIV,   2'b01, 32'hFFFF_FF9C, 32'h0000_0007);
        do_op("b2b_1", K_MULT,  2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        do_op("b2b_2", K_DIVU,  2'b10, 32'hFFFF_FFFF, 32'h0000_0010);
        md_bus.ex_valid = 1'b1;
        md_bus.mthl_op  = 2'b01;
        md_bus.rs_value = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        model_lo = 32'h5A5A_A5A5;
        read_hilo("b2b_mtlo_rd");
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            int          kind;
            logic [1:0]  enc;
            logic [31:0] a, b;
            kind = int'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       a = 32'h8000_0000;
                3:       b = 32'hFFFF_FFFF;
                default: ;
            endcase
            if (kind == K_MULT || kind == K_DIV) enc = 2'b01;
            else enc = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
            do_op("rand", kind, enc, a, b);
            if (i % 4 == 0) read_hilo("rand_rd");
        end
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        test_reset();
        test_plan_vectors();
        test_mthl();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
